imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot loader that programs instruction memory from a byte stream, such as a UART RX, and drives the core's program-write interface (prog_en / prog_addr / prog_data).
- Holds the core in reset while loading, then releases it so fetch starts at the loaded image.
- Streams are validated by a length header, a word-count limit, an inter-byte timeout and an XOR checksum.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 4096, largest accepted word count. A larger header is an error.
- TIMEOUT, 1_000_000, maximum clk cycles allowed between accepted bytes while a load is active.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load. Ignored while busy.
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader can accept a byte. A byte transfers when rx_valid & rx_ready.
- prog_en  out  1  one-cycle instruction-memory write strobe
- prog_addr  out  32  byte address of the write, word aligned
- prog_data  out  32  word written
- cpu_hold  out  1  keeps the core in reset. High during a load and after an error.
- busy  out  1  load in progress
- done  out  1  last load succeeded. Held until the next start.
- error  out  1  last load failed. Held until the next start.
- word_cnt  out  32  number of words written in the current or last load

Behaviour:
- Reset values: all outputs 0 except cpu_hold=1. State IDLE.
- Stream format, in order:
  - 4-byte word count N, little-endian.
  - N words, 4 bytes each, little-endian (first byte = bits [7:0]).
  - 1 checksum byte, equal to the XOR of every preceding byte of the stream, including the length bytes.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Clear byte index, word index, running XOR, timeout counter, word_cnt, done and error.
  - Set cpu_hold=1 and busy=1, then go to LEN.
- rx_ready=1 only in LEN, DATA and CSUM. It is 0 in every other state, including the WRITE cycle.
- LEN: collect 4 bytes.
  - After the 4th byte: N > MAX_WORDS -> ERR; N == 0 -> CSUM; else -> DATA.
- DATA: collect 4 bytes into the word register, then -> WRITE.
- WRITE: exactly one cycle.
  - prog_en=1, prog_addr = BASE_ADDR + 4*word_index (32-bit wrap), prog_data = assembled word.
  - Increment word_index and word_cnt.
  - If word_index+1 == N -> CSUM, else -> DATA.
- prog_addr and prog_data hold their last values when prog_en=0.
- CSUM: accept 1 byte.
  - Byte equals running XOR -> DONE, with done=1, busy=0, cpu_hold=0.
  - Mismatch -> ERR, with error=1, busy=0, cpu_hold stays 1.
- Timeout:
  - The counter runs in LEN, DATA and CSUM and clears on every accepted byte.
  - Reaching TIMEOUT -> ERR.
  - Words already written stay in memory; the core stays held.
- A start pulse during busy is ignored. rx bytes presented in IDLE, DONE or ERR are not accepted (rx_ready=0).
- Simultaneous start and rx_valid in IDLE: start is taken, the byte is not accepted that cycle.
- Asynchronous reset mid-load: return to IDLE with cpu_hold=1. A partial image stays in memory and no further writes occur.
- Throughput: one write per 4 accepted bytes plus the 1 WRITE cycle. The upstream source must tolerate rx_ready=0 for 1 cycle per word.

Test Plan:
- Nominal load:
  - start, then bytes 02 00 00 00 93 00 40 00 13 01 10 00 D3.
  - Expect prog_en pulses (addr 0x0, data 0x00400093) and (addr 0x4, data 0x00100113).
  - Then done=1, cpu_hold=0, word_cnt=2, error=0.
- Bad checksum: the same stream with last byte D2 -> both writes occur, then error=1, done=0, cpu_hold=1.
- Oversize header: with MAX_WORDS=4, bytes 05 00 00 00 -> error=1 after the 4th byte, no prog_en, rx_ready=0 afterwards.
- Empty image: bytes 00 00 00 00 00 -> done=1, cpu_hold=0, word_cnt=0, no prog_en.
- Timeout: with TIMEOUT=16, send 02 00 00 00 93 then stall -> error=1 after 16 idle cycles, no prog_en issued.
- Reset and busy handling:
  - Assert rst_n=0 mid-DATA -> outputs return to reset values with cpu_hold=1.
  - A fresh start then loads correctly.
  - A start pulse during busy does not restart the load.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into 32-bit program-memory writes.
// One write cycle per 4 accepted bytes, during which rx_ready drops. An inter-byte timeout aborts the load.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] word_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic [31:0] n_words;
    logic [31:0] to_cnt;
    logic [7:0]  xor_acc;

    logic        accept;
    logic        timed_out;
    logic [31:0] shreg_next;
    logic [31:0] word_cnt_inc;

    assign rx_ready     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept       = rx_valid && rx_ready;
    // Bytes arrive LSB first, so shifting in from the top leaves the first byte in [7:0].
    assign shreg_next   = {rx_data, shreg[31:8]};
    assign word_cnt_inc = word_cnt + 32'd1;
    assign timed_out    = rx_ready && !accept && (to_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            byte_idx  <= 2'd0;
            shreg     <= 32'd0;
            n_words   <= 32'd0;
            to_cnt    <= 32'd0;
            xor_acc   <= 8'd0;
            prog_en   <= 1'b0;
            prog_addr <= 32'd0;
            prog_data <= 32'd0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            word_cnt  <= 32'd0;
        end else begin
            prog_en <= 1'b0;

            if (rx_ready) begin
                to_cnt <= accept ? 32'd0 : to_cnt + 32'd1;
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        byte_idx <= 2'd0;
                        xor_acc  <= 8'd0;
                        to_cnt   <= 32'd0;
                        word_cnt <= 32'd0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (timed_out) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else if (accept) begin
                        shreg    <= shreg_next;
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            n_words <= shreg_next;
                            if (shreg_next > 32'(MAX_WORDS)) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_ERR;
                            end else if (shreg_next == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (timed_out) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else if (accept) begin
                        shreg    <= shreg_next;
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Strobe is registered here so prog_en lines up with the WRITE cycle.
                        if (byte_idx == 2'd3) begin
                            prog_en   <= 1'b1;
                            prog_addr <= BASE_ADDR + {word_cnt[29:0], 2'b00};
                            prog_data <= shreg_next;
                            state     <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    word_cnt <= word_cnt_inc;
                    state    <= (word_cnt_inc == n_words) ? S_CSUM : S_DATA;
                end

                S_CSUM: begin
                    if (timed_out) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else if (accept) begin
                        busy <= 1'b0;
                        if (rx_data == xor_acc) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with MAX_WORDS=4 and TIMEOUT=16.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] word_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    logic [7:0] nom [13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h40, 8'h00,
                             8'h13, 8'h01, 8'h10, 8'h00, 8'hD3};

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .prog_en(prog_en),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_en === 1'b1) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_data);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_hold, busy, done, error, prog_en, rx_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 100000", {cpu_hold, busy, done, error, prog_en, rx_ready});
        end
        checks++;
        if ({prog_addr, prog_data, word_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_buses: addr=%h data=%h cnt=%0d required 0", prog_addr, prog_data, word_cnt);
        end
    endtask

    task automatic test_nominal();
        wa.delete();
        wd.delete();
        pulse_start();
        checks++;
        if ({busy, cpu_hold, rx_ready, done} !== 4'b1110) begin
            errors++;
            $display("FAIL nom_busy: busy/hold/rdy/done=%b required 1110", {busy, cpu_hold, rx_ready, done});
        end
        for (int i = 0; i < 13; i++) send_byte(nom[i]);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL nom_status: done/err/hold/busy=%b required 1000", {done, error, cpu_hold, busy});
        end
        checks++;
        if (word_cnt !== 32'd2) begin
            errors++;
            $display("FAIL nom_word_cnt: got %0d required 2", word_cnt);
        end
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL nom_pulses: got %0d required 2", wa.size());
        end else if (wa[0] !== 32'h0 || wd[0] !== 32'h00400093 || wa[1] !== 32'h4 || wd[1] !== 32'h00100113) begin
            errors++;
            $display("FAIL nom_writes: got %h:%h %h:%h required 0:00400093 4:00100113", wa[0], wd[0], wa[1], wd[1]);
        end
        checks++;
        if (prog_addr !== 32'h4 || prog_data !== 32'h00100113) begin
            errors++;
            $display("FAIL nom_hold_bus: addr=%h data=%h required 4 00100113", prog_addr, prog_data);
        end
        rx_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_rx_ready: got %b required 0", rx_ready);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_bad_csum();
        wa.delete();
        wd.delete();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(nom[i]);
        send_byte(8'hD2);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b0110) begin
            errors++;
            $display("FAIL csum_status: done/err/hold/busy=%b required 0110", {done, error, cpu_hold, busy});
        end
        checks++;
        if (wa.size() != 2 || wa[0] !== 32'h0 || wd[1] !== 32'h00100113) begin
            errors++;
            $display("FAIL csum_writes: count=%0d required 2 at addr 0 and 4", wa.size());
        end
    endtask

    task automatic test_oversize();
        wa.delete();
        pulse_start();
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL over_early: error=%b required 0 before 4th byte", error);
        end
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if ({error, done, cpu_hold, busy, rx_ready} !== 5'b10100) begin
            errors++;
            $display("FAIL over_status: err/done/hold/busy/rdy=%b required 10100", {error, done, cpu_hold, busy, rx_ready});
        end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL over_pulses: got %0d required 0", wa.size());
        end
    endtask

    task automatic test_empty();
        wa.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b1000 || word_cnt !== 32'd0) begin
            errors++;
            $display("FAIL empty_status: done/err/hold/busy=%b cnt=%0d required 1000 cnt 0",
                     {done, error, cpu_hold, busy}, word_cnt);
        end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL empty_pulses: got %0d required 0", wa.size());
        end
    endtask

    task automatic test_timeout();
        wa.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(nom[i]);
        for (int i = 0; i < 16; i++) @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: error=%b busy=%b required 0 1 after 15 idle cycles", error, busy);
        end
        @(negedge clk);
        checks++;
        if ({error, done, cpu_hold, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL tmo_status: err/done/hold/busy=%b required 1010", {error, done, cpu_hold, busy});
        end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL tmo_pulses: got %0d required 0", wa.size());
        end
    endtask

    task automatic test_reset_mid();
        wa.delete();
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(nom[i]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, busy, done, error, prog_en, rx_ready} !== 6'b100000 || word_cnt !== 32'd0 || prog_addr !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b cnt=%0d addr=%h required 100000 0 0",
                     {cpu_hold, busy, done, error, prog_en, rx_ready}, word_cnt, prog_addr);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (wa.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_writes: count=%0d busy=%b required 1 0", wa.size(), busy);
        end
    endtask

    task automatic test_start_while_busy();
        wa.delete();
        wd.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(nom[i]);
        pulse_start();
        for (int i = 6; i < 13; i++) send_byte(nom[i]);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || word_cnt !== 32'd2) begin
            errors++;
            $display("FAIL busy_start: done/err/hold=%b cnt=%0d required 100 2", {done, error, cpu_hold}, word_cnt);
        end
        checks++;
        if (wa.size() != 2 || wd[0] !== 32'h00400093 || wa[1] !== 32'h4) begin
            errors++;
            $display("FAIL busy_writes: count=%0d required 2 with first data 00400093", wa.size());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #22;
        test_reset();
        rst_n = 1'b1;
        test_nominal();
        test_bad_csum();
        test_oversize();
        test_empty();
        test_timeout();
        test_reset_mid();
        test_nominal();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
